// File: rtl/mem_stage_pipe_if.sv
// mem_stage_pipe_if: single-outstanding data-memory request/acknowledge bus.
//   req/we/addr/be/wdata : request side, driven by the master and held until ack
//   ack/rdata            : completion side, driven by the slave; rdata valid with ack
interface mem_stage_pipe_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [XLEN/8-1:0] be;
    logic [XLEN-1:0]   wdata;
    logic              ack;
    logic [XLEN-1:0]   rdata;
    modport master (output req, we, addr, be, wdata, input ack, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: registered RISC-V MEM stage with branch resolve, load/store formatting and dmem handshake.
//   clk, rst                : clock, asynchronous active-high reset
//   i_valid, i_ctrl_*       : instruction from EX and its control bits
//   i_mem_size/unsigned     : access size (0=B,1=H,2=W,3=D) and zero-extend flag
//   i_alu_*, i_mem_write_data : branch condition, address/result, right-aligned store data
//   o_stall                 : hold EX while an access is in flight
//   dmem                    : data-memory bus (master side)
//   o_valid, o_alu_result, o_mem_read_data, o_ctrl_pc_src, o_misalign : WB-side outputs
module mem_stage_pipe #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    input  logic            i_ctrl_mem_branch,
    input  logic            i_ctrl_mem_read,
    input  logic            i_ctrl_mem_write,
    input  logic [1:0]      i_mem_size,
    input  logic            i_mem_unsigned,
    input  logic            i_alu_branch_take,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic [XLEN-1:0] i_mem_write_data,
    output logic            o_stall,
    mem_stage_pipe_if.master dmem,
    output logic            o_valid,
    output logic [XLEN-1:0] o_alu_result,
    output logic [XLEN-1:0] o_mem_read_data,
    output logic            o_ctrl_pc_src,
    output logic            o_misalign
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t r_state, w_next;

    logic              r_we, r_uns, r_pc_pend;
    logic [ADDR_W-1:0] r_addr;
    logic [NB-1:0]     r_be;
    logic [XLEN-1:0]   r_wdata;
    logic [OW-1:0]     r_off;
    logic [1:0]        r_size;

    logic              w_mem, w_mis, w_accept, w_pc;
    logic [2:0]        w_lo3;
    logic [OW-1:0]     w_off;
    logic [NB-1:0]     w_be;
    logic [XLEN-1:0]   w_wdata, w_sh, w_fmt;

    always_comb begin
        w_lo3    = i_alu_result[2:0];
        w_off    = i_alu_result[OW-1:0];
        w_mem    = i_ctrl_mem_read | i_ctrl_mem_write;
        // size 3 is only legal on a 64-bit datapath
        w_mis    = i_mem_size == 2'd1 ? w_lo3[0] :
                   i_mem_size == 2'd2 ? |w_lo3[1:0] :
                   i_mem_size == 2'd3 ? (XLEN == 32) || (|w_lo3) : 1'b0;
        w_accept = i_valid & w_mem & ~w_mis;
        w_pc     = i_ctrl_mem_branch & i_alu_branch_take & ~i_ctrl_mem_write;
        w_be     = i_mem_size == 2'd3 ? '1 :
                   (i_mem_size == 2'd2 ? NB'(4'hF) : i_mem_size == 2'd1 ? NB'(2'b11) : NB'(1'b1)) << w_off;
        // accesses are aligned, so replicating across lanes already places bit 0 at lane off
        w_wdata  = i_mem_size == 2'd0 ? {NB{i_mem_write_data[7:0]}} :
                   i_mem_size == 2'd1 ? {(NB/2){i_mem_write_data[15:0]}} :
                   i_mem_size == 2'd2 ? {(NB/4){i_mem_write_data[31:0]}} : i_mem_write_data;
        w_sh     = dmem.rdata >> {r_off, 3'b000};
        w_fmt    = r_size == 2'd0 ? (r_uns ? XLEN'(w_sh[7:0])  : XLEN'($signed(w_sh[7:0]))) :
                   r_size == 2'd1 ? (r_uns ? XLEN'(w_sh[15:0]) : XLEN'($signed(w_sh[15:0]))) :
                   r_size == 2'd2 ? (r_uns ? XLEN'(w_sh[31:0]) : XLEN'($signed(w_sh[31:0]))) : w_sh;
    end

    always_comb begin
        w_next = r_state == IDLE ? (w_accept ? BUSY : IDLE) : (dmem.ack ? IDLE : BUSY);
    end

    always_comb begin
        o_stall    = r_state == BUSY;
        dmem.req   = r_state == BUSY;
        dmem.we    = r_we;
        dmem.addr  = r_addr;
        dmem.be    = r_be;
        dmem.wdata = r_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_we            <= 1'b0;
            r_uns           <= 1'b0;
            r_pc_pend       <= 1'b0;
            r_addr          <= '0;
            r_be            <= '0;
            r_wdata         <= '0;
            r_off           <= '0;
            r_size          <= '0;
            o_valid         <= 1'b0;
            o_alu_result    <= '0;
            o_mem_read_data <= '0;
            o_ctrl_pc_src   <= 1'b0;
            o_misalign      <= 1'b0;
        end else begin
            r_state       <= w_next;
            o_valid       <= 1'b0;
            o_ctrl_pc_src <= 1'b0;
            o_misalign    <= 1'b0;
            if (r_state == IDLE && i_valid) begin
                o_alu_result <= i_alu_result;
                if (w_accept) begin
                    r_we      <= i_ctrl_mem_write;
                    r_addr    <= i_alu_result[ADDR_W-1:0];
                    r_be      <= w_be;
                    r_wdata   <= w_wdata;
                    r_off     <= w_off;
                    r_size    <= i_mem_size;
                    r_uns     <= i_mem_unsigned;
                    r_pc_pend <= w_pc;
                end else begin
                    o_valid         <= 1'b1;
                    o_ctrl_pc_src   <= w_pc;
                    o_misalign      <= w_mem & w_mis;
                    o_mem_read_data <= '0;
                end
            end else if (r_state == BUSY && dmem.ack) begin
                o_valid         <= 1'b1;
                o_ctrl_pc_src   <= r_pc_pend;
                o_mem_read_data <= r_we ? '0 : w_fmt;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_pipe.sv
// tb_mem_stage_pipe: directed checks of mem_stage_pipe at XLEN=32 and XLEN=64.
module tb_mem_stage_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        v32, v64, br, rd, wr, uns, tk;
    logic [1:0]  sz;
    logic [63:0] alu, wd;
    logic        st32, val32, pc32, mis32, st64, val64, pc64, mis64;
    logic [31:0] res32, rdo32;
    logic [63:0] res64, rdo64;
    int          nvec = 0;
    int          nerr = 0;

    mem_stage_pipe_if #(.XLEN(32), .ADDR_W(32)) m32();
    mem_stage_pipe_if #(.XLEN(64), .ADDR_W(32)) m64();

    mem_stage_pipe #(.XLEN(32), .ADDR_W(32)) u32 (
        .clk(clk), .rst(rst), .i_valid(v32), .i_ctrl_mem_branch(br), .i_ctrl_mem_read(rd),
        .i_ctrl_mem_write(wr), .i_mem_size(sz), .i_mem_unsigned(uns), .i_alu_branch_take(tk),
        .i_alu_result(alu[31:0]), .i_mem_write_data(wd[31:0]), .o_stall(st32), .dmem(m32.master),
        .o_valid(val32), .o_alu_result(res32), .o_mem_read_data(rdo32), .o_ctrl_pc_src(pc32),
        .o_misalign(mis32)
    );

    mem_stage_pipe #(.XLEN(64), .ADDR_W(32)) u64 (
        .clk(clk), .rst(rst), .i_valid(v64), .i_ctrl_mem_branch(br), .i_ctrl_mem_read(rd),
        .i_ctrl_mem_write(wr), .i_mem_size(sz), .i_mem_unsigned(uns), .i_alu_branch_take(tk),
        .i_alu_result(alu), .i_mem_write_data(wd), .o_stall(st64), .dmem(m64.master),
        .o_valid(val64), .o_alu_result(res64), .o_mem_read_data(rdo64), .o_ctrl_pc_src(pc64),
        .o_misalign(mis64)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        nvec++; if (m32.req !== 1'b0) begin nerr++; $display("FAIL rst_req got %0h exp 0", m32.req); end
        nvec++; if (st32 !== 1'b0) begin nerr++; $display("FAIL rst_stall got %0h exp 0", st32); end
        nvec++; if (val32 !== 1'b0) begin nerr++; $display("FAIL rst_valid got %0h exp 0", val32); end
        nvec++; if (res32 !== 32'h0) begin nerr++; $display("FAIL rst_alu got %h exp 0", res32); end
        nvec++; if (m64.req !== 1'b0) begin nerr++; $display("FAIL rst_req64 got %0h exp 0", m64.req); end
        #10 rst = 1'b0;
        tick();
    endtask

    task automatic test_branch;
        v32 = 1'b1; br = 1'b1; tk = 1'b1; alu = 64'h100;
        tick();
        v32 = 1'b0; br = 1'b0; tk = 1'b0;
        nvec++; if (val32 !== 1'b1) begin nerr++; $display("FAIL br_valid got %0h exp 1", val32); end
        nvec++; if (pc32 !== 1'b1) begin nerr++; $display("FAIL br_pcsrc got %0h exp 1", pc32); end
        nvec++; if (res32 !== 32'h100) begin nerr++; $display("FAIL br_alu got %h exp 100", res32); end
        nvec++; if (mis32 !== 1'b0) begin nerr++; $display("FAIL br_mis got %0h exp 0", mis32); end
        nvec++; if (st32 !== 1'b0) begin nerr++; $display("FAIL br_stall got %0h exp 0", st32); end
        tick();
        nvec++; if (val32 !== 1'b0) begin nerr++; $display("FAIL br_valid_drop got %0h exp 0", val32); end
        nvec++; if (pc32 !== 1'b0) begin nerr++; $display("FAIL br_pcsrc_drop got %0h exp 0", pc32); end
    endtask

    task automatic test_lb(input logic u, input int lat, input logic [31:0] exp);
        v32 = 1'b1; rd = 1'b1; sz = 2'd0; uns = u; alu = 64'h1003;
        tick();
        v32 = 1'b0; rd = 1'b0; uns = 1'b0;
        for (int i = 0; i < lat; i++) begin
            nvec++; if (st32 !== 1'b1) begin nerr++; $display("FAIL lb_stall[%0d] got %0h exp 1", i, st32); end
            nvec++; if (m32.req !== 1'b1) begin nerr++; $display("FAIL lb_req[%0d] got %0h exp 1", i, m32.req); end
            nvec++; if (m32.be !== 4'b1000) begin nerr++; $display("FAIL lb_be[%0d] got %b exp 1000", i, m32.be); end
            nvec++; if (m32.addr !== 32'h1003) begin nerr++; $display("FAIL lb_addr[%0d] got %h exp 1003", i, m32.addr); end
            nvec++; if (m32.we !== 1'b0) begin nerr++; $display("FAIL lb_we[%0d] got %0h exp 0", i, m32.we); end
            nvec++; if (val32 !== 1'b0) begin nerr++; $display("FAIL lb_early_valid[%0d] got %0h exp 0", i, val32); end
            if (i == lat - 1) begin m32.ack = 1'b1; m32.rdata = 32'h80FF_FF00; end
            tick();
        end
        m32.ack = 1'b0;
        nvec++; if (val32 !== 1'b1) begin nerr++; $display("FAIL lb_valid got %0h exp 1", val32); end
        nvec++; if (rdo32 !== exp) begin nerr++; $display("FAIL lb_data got %h exp %h", rdo32, exp); end
        nvec++; if (st32 !== 1'b0) begin nerr++; $display("FAIL lb_stall_end got %0h exp 0", st32); end
        nvec++; if (m32.req !== 1'b0) begin nerr++; $display("FAIL lb_req_end got %0h exp 0", m32.req); end
        tick();
        nvec++; if (val32 !== 1'b0) begin nerr++; $display("FAIL lb_valid_pulse got %0h exp 0", val32); end
    endtask

    task automatic test_sh;
        v32 = 1'b1; wr = 1'b1; rd = 1'b1; br = 1'b1; tk = 1'b1; sz = 2'd1; alu = 64'h2002; wd = 64'hBEEF;
        tick();
        v32 = 1'b0; wr = 1'b0; rd = 1'b0; br = 1'b0; tk = 1'b0;
        nvec++; if (m32.req !== 1'b1) begin nerr++; $display("FAIL sh_req got %0h exp 1", m32.req); end
        nvec++; if (m32.we !== 1'b1) begin nerr++; $display("FAIL sh_we got %0h exp 1", m32.we); end
        nvec++; if (m32.be !== 4'b1100) begin nerr++; $display("FAIL sh_be got %b exp 1100", m32.be); end
        nvec++; if (m32.wdata[31:16] !== 16'hBEEF) begin nerr++; $display("FAIL sh_wdata got %h exp beef", m32.wdata[31:16]); end
        nvec++; if (val32 !== 1'b0) begin nerr++; $display("FAIL sh_early_valid got %0h exp 0", val32); end
        m32.ack = 1'b1; m32.rdata = 32'hFFFF_FFFF;
        tick();
        m32.ack = 1'b0;
        nvec++; if (val32 !== 1'b1) begin nerr++; $display("FAIL sh_valid got %0h exp 1", val32); end
        nvec++; if (rdo32 !== 32'h0) begin nerr++; $display("FAIL sh_rdata got %h exp 0", rdo32); end
        nvec++; if (pc32 !== 1'b0) begin nerr++; $display("FAIL sh_pcsrc got %0h exp 0", pc32); end
        nvec++; if (res32 !== 32'h2002) begin nerr++; $display("FAIL sh_alu got %h exp 2002", res32); end
        tick();
        nvec++; if (val32 !== 1'b0) begin nerr++; $display("FAIL sh_valid_pulse got %0h exp 0", val32); end
    endtask

    task automatic test_misalign;
        v32 = 1'b1; rd = 1'b1; sz = 2'd2; alu = 64'h3001;
        tick();
        nvec++; if (m32.req !== 1'b0) begin nerr++; $display("FAIL mw_req got %0h exp 0", m32.req); end
        nvec++; if (st32 !== 1'b0) begin nerr++; $display("FAIL mw_stall got %0h exp 0", st32); end
        nvec++; if (val32 !== 1'b1) begin nerr++; $display("FAIL mw_valid got %0h exp 1", val32); end
        nvec++; if (mis32 !== 1'b1) begin nerr++; $display("FAIL mw_mis got %0h exp 1", mis32); end
        sz = 2'd3; alu = 64'h3000;
        tick();
        nvec++; if (m32.req !== 1'b0) begin nerr++; $display("FAIL md_req got %0h exp 0", m32.req); end
        nvec++; if (st32 !== 1'b0) begin nerr++; $display("FAIL md_stall got %0h exp 0", st32); end
        nvec++; if (val32 !== 1'b1) begin nerr++; $display("FAIL md_valid got %0h exp 1", val32); end
        nvec++; if (mis32 !== 1'b1) begin nerr++; $display("FAIL md_mis got %0h exp 1", mis32); end
        sz = 2'd1; alu = 64'h3005;
        tick();
        nvec++; if (mis32 !== 1'b1) begin nerr++; $display("FAIL mh_mis got %0h exp 1", mis32); end
        v32 = 1'b0; rd = 1'b0; sz = 2'd0; m32.ack = 1'b1;
        tick();
        m32.ack = 1'b0;
        nvec++; if (val32 !== 1'b0) begin nerr++; $display("FAIL idle_ack_valid got %0h exp 0", val32); end
        nvec++; if (mis32 !== 1'b0) begin nerr++; $display("FAIL idle_ack_mis got %0h exp 0", mis32); end
        nvec++; if (st32 !== 1'b0) begin nerr++; $display("FAIL idle_ack_stall got %0h exp 0", st32); end
    endtask

    task automatic test_back_to_back;
        v32 = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            alu = 64'(i * 16);
            tick();
            nvec++; if (val32 !== 1'b1) begin nerr++; $display("FAIL b2b_valid[%0d] got %0h exp 1", i, val32); end
            nvec++; if (res32 !== 32'(i * 16)) begin nerr++; $display("FAIL b2b_alu[%0d] got %h exp %h", i, res32, 32'(i * 16)); end
        end
        v32 = 1'b0;
        tick();
    endtask

    task automatic test_reset_busy;
        v32 = 1'b1; rd = 1'b1; sz = 2'd2; alu = 64'h4000;
        tick();
        v32 = 1'b0; rd = 1'b0;
        nvec++; if (m32.req !== 1'b1) begin nerr++; $display("FAIL rb_req_pre got %0h exp 1", m32.req); end
        #2 rst = 1'b1;
        #1;
        nvec++; if (m32.req !== 1'b0) begin nerr++; $display("FAIL rb_req got %0h exp 0", m32.req); end
        nvec++; if (st32 !== 1'b0) begin nerr++; $display("FAIL rb_stall got %0h exp 0", st32); end
        #2 rst = 1'b0;
        m32.ack = 1'b1; m32.rdata = 32'h1234_5678;
        tick();
        m32.ack = 1'b0;
        nvec++; if (val32 !== 1'b0) begin nerr++; $display("FAIL rb_late_ack_valid got %0h exp 0", val32); end
        nvec++; if (m32.req !== 1'b0) begin nerr++; $display("FAIL rb_late_ack_req got %0h exp 0", m32.req); end
    endtask

    task automatic test_x64;
        v64 = 1'b1; rd = 1'b1; sz = 2'd3; uns = 1'b0; alu = 64'h8;
        tick();
        v64 = 1'b0; rd = 1'b0;
        nvec++; if (m64.req !== 1'b1) begin nerr++; $display("FAIL ld_req got %0h exp 1", m64.req); end
        nvec++; if (m64.be !== 8'hFF) begin nerr++; $display("FAIL ld_be got %h exp ff", m64.be); end
        nvec++; if (m64.addr !== 32'h8) begin nerr++; $display("FAIL ld_addr got %h exp 8", m64.addr); end
        m64.ack = 1'b1; m64.rdata = 64'h8000_0000_0000_0001;
        tick();
        m64.ack = 1'b0;
        nvec++; if (val64 !== 1'b1) begin nerr++; $display("FAIL ld_valid got %0h exp 1", val64); end
        nvec++; if (rdo64 !== 64'h8000_0000_0000_0001) begin nerr++; $display("FAIL ld_data got %h exp 8000000000000001", rdo64); end
        nvec++; if (mis64 !== 1'b0) begin nerr++; $display("FAIL ld_mis got %0h exp 0", mis64); end
        v64 = 1'b1; rd = 1'b1; sz = 2'd2; alu = 64'hC;
        tick();
        v64 = 1'b0; rd = 1'b0;
        nvec++; if (m64.be !== 8'hF0) begin nerr++; $display("FAIL lw64_be got %h exp f0", m64.be); end
        m64.ack = 1'b1; m64.rdata = 64'hF000_0000_0000_0000;
        tick();
        m64.ack = 1'b0;
        nvec++; if (val64 !== 1'b1) begin nerr++; $display("FAIL lw64_valid got %0h exp 1", val64); end
        nvec++; if (rdo64 !== 64'hFFFF_FFFF_F000_0000) begin nerr++; $display("FAIL lw64_data got %h exp fffffffff0000000", rdo64); end
    endtask

    initial begin
        rst = 1'b1; v32 = 1'b0; v64 = 1'b0; br = 1'b0; rd = 1'b0; wr = 1'b0; uns = 1'b0; tk = 1'b0;
        sz = 2'd0; alu = '0; wd = '0;
        m32.ack = 1'b0; m32.rdata = '0; m64.ack = 1'b0; m64.rdata = '0;
        test_reset();
        test_branch();
        test_lb(1'b0, 4, 32'hFFFF_FF80);
        test_lb(1'b1, 1, 32'h0000_0080);
        test_sh();
        test_misalign();
        test_back_to_back();
        test_reset_busy();
        test_x64();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
